// File: rtl/maze_mem_arbiter.sv
`default_nettype none
// ============================================================================
// maze_mem_arbiter : shares the single-port maze bit memory between the solver
//                    (r0) and the host loader/readback path (r1)
// Rev 1.0
// ============================================================================
module maze_mem_arbiter #(
  parameter int MAZE_WIDTH   = 6,
  parameter int PRIO_MODE    = 0,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r0_req_i,
  input  logic                  r0_we_i,
  input  logic [MAZE_WIDTH-1:0] r0_row_i,
  input  logic [MAZE_WIDTH-1:0] r0_col_i,
  input  logic                  r0_wdata_i,
  output logic                  r0_gnt_o,
  output logic                  r0_rvalid_o,
  output logic                  r0_rdata_o,
  input  logic                  r1_req_i,
  input  logic                  r1_we_i,
  input  logic [MAZE_WIDTH-1:0] r1_row_i,
  input  logic [MAZE_WIDTH-1:0] r1_col_i,
  input  logic                  r1_wdata_i,
  output logic                  r1_gnt_o,
  output logic                  r1_rvalid_o,
  output logic                  r1_rdata_o,
  output logic [MAZE_WIDTH-1:0] mem_row_o,
  output logic [MAZE_WIDTH-1:0] mem_col_o,
  output logic                  mem_oe_o,
  output logic                  mem_we_o,
  output logic                  mem_wdata_o,
  input  logic                  mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  localparam logic [7:0] c_starve_lim = 8'(STARVE_LIMIT);

  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic [7:0]            starve_q, starve_d;
  logic                  we_q, we_d;
  logic [MAZE_WIDTH-1:0] row_q, row_d;
  logic [MAZE_WIDTH-1:0] col_q, col_d;
  logic                  wdata_q, wdata_d;
  logic                  tag_vld_q, tag_vld_d;
  logic                  tag_id_q, tag_id_d;
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;
  logic                  rdata0_q, rdata0_d;
  logic                  rdata1_q, rdata1_d;

  logic elig0, elig1, sel0, sel1, starved;

  always_comb begin
    elig0   = r0_req_i && (state_q != GNT0);
    elig1   = r1_req_i && (state_q != GNT1);
    starved = (starve_q == c_starve_lim);
    sel0    = 1'b0;
    sel1    = 1'b0;
    if (PRIO_MODE == 0) begin
      // ptr_q names the last winner; the other side takes a tie
      sel0 = elig0 && (!elig1 || ptr_q);
      sel1 = elig1 && !sel0;
    end else begin
      sel1 = elig1 && (starved || !elig0);
      sel0 = elig0 && !sel1;
    end
  end

  always_comb begin
    state_d  = IDLE;
    ptr_d    = ptr_q;
    we_d     = we_q;
    row_d    = row_q;
    col_d    = col_q;
    wdata_d  = wdata_q;
    starve_d = starve_q;
    if (sel0) begin
      state_d = GNT0;
      ptr_d   = 1'b0;
      we_d    = r0_we_i;
      row_d   = r0_row_i;
      col_d   = r0_col_i;
      wdata_d = r0_wdata_i;
    end else if (sel1) begin
      state_d = GNT1;
      ptr_d   = 1'b1;
      we_d    = r1_we_i;
      row_d   = r1_row_i;
      col_d   = r1_col_i;
      wdata_d = r1_wdata_i;
    end
    if (!r1_req_i || sel1) begin
      starve_d = 8'd0;
    end else if (elig1 && !starved) begin
      starve_d = starve_q + 8'd1;
    end

    // Read return: tag follows the command cycle, data lands one cycle later
    tag_vld_d = (state_q != IDLE) && !we_q;
    tag_id_d  = (state_q == GNT1);
    rvalid0_d = tag_vld_q && !tag_id_q;
    rvalid1_d = tag_vld_q && tag_id_q;
    rdata0_d  = rvalid0_d ? mem_rdata_i : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_rdata_i : rdata1_q;

    r0_gnt_o    = (state_q == GNT0);
    r1_gnt_o    = (state_q == GNT1);
    mem_oe_o    = (state_q != IDLE) && !we_q;
    mem_we_o    = (state_q != IDLE) && we_q;
    mem_row_o   = row_q;
    mem_col_o   = col_q;
    mem_wdata_o = wdata_q;
    r0_rvalid_o = rvalid0_q;
    r1_rvalid_o = rvalid1_q;
    r0_rdata_o  = rdata0_q;
    r1_rdata_o  = rdata1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b1;
      starve_q  <= 8'd0;
      we_q      <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      wdata_q   <= 1'b0;
      tag_vld_q <= 1'b0;
      tag_id_q  <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= 1'b0;
      rdata1_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      starve_q  <= starve_d;
      we_q      <= we_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wdata_q   <= wdata_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

endmodule
`default_nettype wire
